// File: rtl/bg_mean_estimator_if.sv
// Pixel stream into the background mean estimator: valid/ready handshake with one
// RGB sample per transfer.
interface bg_mean_estimator_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_r;
    logic [7:0] pix_g;
    logic [7:0] pix_b;

    modport master (output pix_valid, pix_r, pix_g, pix_b, input pix_ready);
    modport slave  (input pix_valid, pix_r, pix_g, pix_b, output pix_ready);
endinterface

// File: rtl/bg_mean_estimator.sv
// Accumulates a block of background pixels, divides each channel sum by the pixel
// count with three parallel restoring dividers, and holds the mean colour until Ack.
module bg_mean_estimator #(
    parameter int unsigned PIX_COUNT = 16,
    parameter int unsigned SUM_W     = 20
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Ack,
    bg_mean_estimator_if.slave pix,
    output logic [7:0]         red_exp,
    output logic [7:0]         green_exp,
    output logic [7:0]         blue_exp,
    output logic               Qi,
    output logic               Qa,
    output logic               Qv,
    output logic               Qd
);

    localparam int unsigned      CntW    = $clog2(SUM_W);
    localparam logic [SUM_W-1:0] Divisor = SUM_W'(PIX_COUNT);
    localparam logic [SUM_W-1:0] LastPix = SUM_W'(PIX_COUNT - 1);
    localparam logic [CntW-1:0]  DivLast = CntW'(SUM_W - 1);

    typedef enum logic [3:0] {
        StIdle   = 4'b0001,
        StAccum  = 4'b0010,
        StDivide = 4'b0100,
        StDone   = 4'b1000
    } state_e;

    state_e           state;
    logic [SUM_W-1:0] sum [3];
    logic [SUM_W-1:0] dvd [3];
    logic [SUM_W-1:0] rem [3];
    // Only the low 8 quotient bits survive; the last bit comes straight from q_bit.
    logic [6:0]       quo [3];
    logic [SUM_W-1:0] pix_cnt;
    logic [CntW-1:0]  div_cnt;

    logic [7:0]       sample    [3];
    logic [SUM_W-1:0] sum_add   [3];
    logic [SUM_W-1:0] rem_shift [3];
    logic [SUM_W-1:0] rem_next  [3];
    logic [2:0]       q_bit;
    logic             xfer;

    assign {Qd, Qv, Qa, Qi} = state;
    assign pix.pix_ready    = (state == StAccum);
    assign xfer             = pix.pix_valid && (state == StAccum);

    always_comb begin
        sample[0] = pix.pix_r;
        sample[1] = pix.pix_g;
        sample[2] = pix.pix_b;
        q_bit     = '0;
        for (int c = 0; c < 3; c++) begin
            sum_add[c]   = sum[c] + SUM_W'(sample[c]);
            rem_shift[c] = {rem[c][SUM_W-2:0], dvd[c][SUM_W-1]};
            // A set MSB shifted out of rem means the true value already exceeds the divisor.
            q_bit[c]     = rem[c][SUM_W-1] || (rem_shift[c] >= Divisor);
            rem_next[c]  = q_bit[c] ? rem_shift[c] - Divisor : rem_shift[c];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= StIdle;
            pix_cnt   <= '0;
            div_cnt   <= '0;
            red_exp   <= '0;
            green_exp <= '0;
            blue_exp  <= '0;
            for (int c = 0; c < 3; c++) begin
                sum[c] <= '0;
                dvd[c] <= '0;
                rem[c] <= '0;
                quo[c] <= '0;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (Start) begin
                        for (int c = 0; c < 3; c++) sum[c] <= '0;
                        pix_cnt <= '0;
                        state   <= StAccum;
                    end
                end
                StAccum: begin
                    if (xfer) begin
                        pix_cnt <= pix_cnt + SUM_W'(1);
                        for (int c = 0; c < 3; c++) sum[c] <= sum_add[c];
                        if (pix_cnt == LastPix) begin
                            for (int c = 0; c < 3; c++) begin
                                dvd[c] <= sum_add[c];
                                rem[c] <= '0;
                                quo[c] <= '0;
                            end
                            div_cnt <= DivLast;
                            state   <= StDivide;
                        end
                    end
                end
                StDivide: begin
                    for (int c = 0; c < 3; c++) begin
                        dvd[c] <= {dvd[c][SUM_W-2:0], 1'b0};
                        rem[c] <= rem_next[c];
                        quo[c] <= {quo[c][5:0], q_bit[c]};
                    end
                    if (div_cnt == '0) begin
                        red_exp   <= {quo[0], q_bit[0]};
                        green_exp <= {quo[1], q_bit[1]};
                        blue_exp  <= {quo[2], q_bit[2]};
                        state     <= StDone;
                    end else begin
                        div_cnt <= div_cnt - CntW'(1);
                    end
                end
                StDone: begin
                    if (Ack) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bg_mean_estimator.sv
// Bench for bg_mean_estimator: three instances (16/20, 3/10, 1/20) driven from a
// vector table, with expected means queued at stimulus time and checked on DONE.
module tb_bg_mean_estimator;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       start [3];
    logic       ack   [3];
    logic       pv    [3];
    logic [7:0] pr    [3];
    logic [7:0] pg    [3];
    logic [7:0] pb    [3];
    logic       rdy   [3];
    logic [7:0] er    [3];
    logic [7:0] eg    [3];
    logic [7:0] eb    [3];
    logic       qi    [3];
    logic       qa    [3];
    logic       qv    [3];
    logic       qd    [3];

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    bg_mean_estimator_if if0 ();
    bg_mean_estimator_if if1 ();
    bg_mean_estimator_if if2 ();

    assign if0.pix_valid = pv[0];
    assign if0.pix_r = pr[0];
    assign if0.pix_g = pg[0];
    assign if0.pix_b = pb[0];
    assign rdy[0] = if0.pix_ready;
    assign if1.pix_valid = pv[1];
    assign if1.pix_r = pr[1];
    assign if1.pix_g = pg[1];
    assign if1.pix_b = pb[1];
    assign rdy[1] = if1.pix_ready;
    assign if2.pix_valid = pv[2];
    assign if2.pix_r = pr[2];
    assign if2.pix_g = pg[2];
    assign if2.pix_b = pb[2];
    assign rdy[2] = if2.pix_ready;

    bg_mean_estimator #(.PIX_COUNT(16), .SUM_W(20)) u_main (
        .Clk(Clk), .Reset(Reset), .Start(start[0]), .Ack(ack[0]), .pix(if0.slave),
        .red_exp(er[0]), .green_exp(eg[0]), .blue_exp(eb[0]),
        .Qi(qi[0]), .Qa(qa[0]), .Qv(qv[0]), .Qd(qd[0])
    );
    bg_mean_estimator #(.PIX_COUNT(3), .SUM_W(10)) u_p3 (
        .Clk(Clk), .Reset(Reset), .Start(start[1]), .Ack(ack[1]), .pix(if1.slave),
        .red_exp(er[1]), .green_exp(eg[1]), .blue_exp(eb[1]),
        .Qi(qi[1]), .Qa(qa[1]), .Qv(qv[1]), .Qd(qd[1])
    );
    bg_mean_estimator #(.PIX_COUNT(1), .SUM_W(20)) u_p1 (
        .Clk(Clk), .Reset(Reset), .Start(start[2]), .Ack(ack[2]), .pix(if2.slave),
        .red_exp(er[2]), .green_exp(eg[2]), .blue_exp(eb[2]),
        .Qi(qi[2]), .Qa(qa[2]), .Qv(qv[2]), .Qd(qd[2])
    );

    typedef enum {PatConst, PatRamp, PatOneTwoTwo} pat_e;

    typedef struct {
        int         dut;
        int         n;
        pat_e       pat;
        logic [7:0] r, g, b;
        bit         bubbles;
        bit         start_pulse;
        logic [7:0] xr, xg, xb;
    } vec_t;

    typedef struct {
        int         dut;
        logic [7:0] r, g, b;
    } exp_t;

    vec_t vecs [6];
    exp_t sb [$];

    function automatic int sumw(input int d);
        return (d == 1) ? 10 : 20;
    endfunction

    function automatic logic [3:0] st(input int d);
        return {qd[d], qv[d], qa[d], qi[d]};
    endfunction

    function automatic logic [23:0] outs(input int d);
        return {er[d], eg[d], eb[d]};
    endfunction

    function automatic logic [7:0] red_of(input vec_t v, input int i);
        case (v.pat)
            PatRamp:      return 8'(i);
            PatOneTwoTwo: return (i == 0) ? 8'd1 : 8'd2;
            default:      return v.r;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
        end
    endtask

    // Latency is reported as the edge number (Start edge = 0) that closes the first
    // cycle in which the state is seen, so DIVIDE entered by the last transfer at
    // edge k is reported as k+1.
    task automatic run_vector(input vec_t v);
        int d, i, j, k, cur, qv_at, qd_at;
        bit bub, ready_bad, hot_bad;
        exp_t e;
        d = v.dut;
        sb.push_back('{dut: d, r: v.xr, g: v.xg, b: v.xb});
        @(negedge Clk) start[d] = 1'b1;
        @(negedge Clk) start[d] = 1'b0;
        i = 0; j = 0; k = 0; bub = 1'b0;
        while (i < v.n && j < 200) begin
            j++;
            start[d] = v.start_pulse && (j == 4);
            if (v.bubbles && bub) begin
                pv[d] = 1'b0;
            end else begin
                pv[d] = 1'b1;
                pr[d] = red_of(v, i);
                pg[d] = v.g;
                pb[d] = v.b;
            end
            bub = !bub;
            if (pv[d] && rdy[d]) begin
                i++;
                k = j;
            end
            @(negedge Clk);
        end
        pv[d] = 1'b0;
        start[d] = 1'b0;
        check("pixels_accepted", i, v.n);
        cur = j + 1; qv_at = -1; qd_at = -1; ready_bad = 0; hot_bad = 0;
        for (int t = 0; t < 200 && qd_at < 0; t++) begin
            if (qv[d] && qv_at < 0) qv_at = cur;
            if (qd[d]) qd_at = cur;
            if ((qv[d] || qd[d]) && rdy[d] !== 1'b0) ready_bad = 1;
            if (!$onehot(st(d))) hot_bad = 1;
            if (qd_at < 0) begin
                @(negedge Clk);
                cur++;
            end
        end
        check("qv_latency", qv_at, k + 1);
        check("qd_latency", qd_at, k + 1 + sumw(d));
        check("ready_low_divide_done", ready_bad, 0);
        check("state_onehot", hot_bad, 0);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("sb_dut", d, e.dut);
            check("mean_rgb", outs(d), {e.r, e.g, e.b});
        end
    endtask

    task automatic ack_and_check(input int d);
        logic [23:0] held;
        held = outs(d);
        @(negedge Clk) ack[d] = 1'b1;
        @(negedge Clk) ack[d] = 1'b0;
        check("ack_to_idle", st(d), 4'b0001);
        check("held_after_ack", outs(d), held);
        check("ready_low_idle", rdy[d], 1'b0);
    endtask

    task automatic hold_done;
        logic [23:0] held;
        bit hold_bad;
        held = outs(0);
        hold_bad = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge Clk);
            start[0] = (t % 7 == 3);
            if (st(0) !== 4'b1000 || outs(0) !== held || rdy[0] !== 1'b0) hold_bad = 1;
        end
        start[0] = 1'b0;
        check("done_held_50", hold_bad, 0);
        @(negedge Clk) begin ack[0] = 1'b1; start[0] = 1'b1; end
        @(negedge Clk) begin ack[0] = 1'b0; start[0] = 1'b0; end
        check("ack_start_to_idle", st(0), 4'b0001);
        repeat (3) @(negedge Clk);
        check("start_not_remembered", st(0), 4'b0001);
        check("held_in_idle", outs(0), held);
    endtask

    task automatic reset_mid_divide;
        int t;
        @(negedge Clk) start[0] = 1'b1;
        @(negedge Clk) begin start[0] = 1'b0; pv[0] = 1'b1; pr[0] = 50; pg[0] = 60; pb[0] = 70; end
        repeat (16) @(negedge Clk);
        pv[0] = 1'b0;
        t = 0;
        while (!qv[0] && t < 50) begin
            @(negedge Clk);
            t++;
        end
        check("reached_divide", qv[0], 1'b1);
        repeat (5) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_state", st(0), 4'b0001);
        check("async_reset_outs", outs(0), 24'd0);
        check("async_reset_ready", rdy[0], 1'b0);
        @(negedge Clk) Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("idle_after_reset", st(0), 4'b0001);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{dut: 0, n: 16, pat: PatConst, r: 100, g: 150, b: 200, bubbles: 0,
                    start_pulse: 0, xr: 100, xg: 150, xb: 200};
        vecs[1] = '{dut: 0, n: 16, pat: PatRamp, r: 0, g: 255, b: 0, bubbles: 0,
                    start_pulse: 0, xr: 7, xg: 255, xb: 0};
        vecs[2] = '{dut: 0, n: 16, pat: PatConst, r: 100, g: 150, b: 200, bubbles: 1,
                    start_pulse: 1, xr: 100, xg: 150, xb: 200};
        vecs[3] = '{dut: 0, n: 16, pat: PatConst, r: 10, g: 20, b: 30, bubbles: 0,
                    start_pulse: 0, xr: 10, xg: 20, xb: 30};
        vecs[4] = '{dut: 1, n: 3, pat: PatOneTwoTwo, r: 0, g: 0, b: 0, bubbles: 0,
                    start_pulse: 0, xr: 1, xg: 0, xb: 0};
        vecs[5] = '{dut: 2, n: 1, pat: PatConst, r: 9, g: 8, b: 7, bubbles: 0,
                    start_pulse: 0, xr: 9, xg: 8, xb: 7};

        Reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0; ack[d] = 1'b0; pv[d] = 1'b0;
            pr[d] = '0; pg[d] = '0; pb[d] = '0;
        end
        repeat (3) @(negedge Clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_state", st(d), 4'b0001);
            check("reset_outs", outs(d), 24'd0);
            check("reset_ready", rdy[d], 1'b0);
        end
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 6; i++) begin
            if (i == 3) reset_mid_divide();
            run_vector(vecs[i]);
            if (i == 0) hold_done();
            else ack_and_check(vecs[i].dut);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
